// File: rtl/wb_scratch_responder_if.sv
// Wishbone classic bus bundle between the SoC WB master port and the scratch responder.
interface wb_scratch_responder_if;
    logic [31:0] wb_addr_i;
    logic [31:0] wb_wdata_i;
    logic [31:0] wb_rdata_o;
    logic        wb_wr_en_i;
    logic [3:0]  wb_byte_en_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_addr_i, wb_wdata_i, wb_wr_en_i, wb_byte_en_i, wb_stb_i, wb_cyc_i,
        output wb_rdata_o, wb_ack_o
    );

    modport master (
        output wb_addr_i, wb_wdata_i, wb_wr_en_i, wb_byte_en_i, wb_stb_i, wb_cyc_i,
        input  wb_rdata_o, wb_ack_o
    );
endinterface

// File: rtl/wb_scratch_responder.sv
// Wishbone classic responder: scratch words, access counter and ID word behind a
// programmable wait-state FSM so the bridge sees realistic ack latency.
module wb_scratch_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
    parameter int unsigned NUM_WORDS   = 16,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h5742_5253
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    wb_scratch_responder_if.slave  wb
);
    localparam int unsigned IW = $clog2(NUM_WORDS);
    localparam logic [IW-1:0] CNT_IDX = IW'(NUM_WORDS - 2);
    localparam logic [IW-1:0] ID_IDX  = IW'(NUM_WORDS - 1);
    localparam logic [3:0]    WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          hit_q, hit_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   access_cnt_q, access_cnt_d;
    logic [31:0]   mem_q [NUM_WORDS];
    logic [31:0]   mem_d [NUM_WORDS];

    logic          req;
    logic          go_ack;
    logic [IW-1:0] in_idx;
    logic          in_hit;
    logic [IW-1:0] txn_idx;
    logic          txn_hit;
    logic          txn_we;
    logic [3:0]    txn_be;
    logic [31:0]   txn_wdata;
    logic          addr_lo_unused;

    always_comb begin
        req            = wb.wb_cyc_i & wb.wb_stb_i;
        in_idx         = wb.wb_addr_i[IW+1:2];
        in_hit         = (wb.wb_addr_i[31:IW+2] == BASE_ADDR[31:IW+2]);
        addr_lo_unused = ^wb.wb_addr_i[1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        go_ack  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = in_idx;
                    hit_d   = in_hit;
                    we_d    = wb.wb_wr_en_i;
                    be_d    = wb.wb_byte_en_i;
                    wdata_d = wb.wb_wdata_i;
                    cnt_d   = WS_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                        go_ack  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_ACK;
                        go_ack  = 1'b1;
                    end
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the commit happens on the sampling edge, so the
    // transaction fields come straight from the bus instead of the latches.
    always_comb begin
        if (state_q == S_IDLE) begin
            txn_idx   = in_idx;
            txn_hit   = in_hit;
            txn_we    = wb.wb_wr_en_i;
            txn_be    = wb.wb_byte_en_i;
            txn_wdata = wb.wb_wdata_i;
        end else begin
            txn_idx   = idx_q;
            txn_hit   = hit_q;
            txn_we    = we_q;
            txn_be    = be_q;
            txn_wdata = wdata_q;
        end
    end

    always_comb begin
        mem_d        = mem_q;
        access_cnt_d = access_cnt_q;
        rdata_d      = '0;
        if (go_ack) begin
            if (txn_hit && txn_we && txn_idx == CNT_IDX) begin
                access_cnt_d = '0;
            end else begin
                access_cnt_d = access_cnt_q + 32'd1;
            end
            if (txn_hit && txn_we && txn_idx < CNT_IDX) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (txn_be[b]) begin
                        mem_d[txn_idx][8*b +: 8] = txn_wdata[8*b +: 8];
                    end
                end
            end
            if (txn_hit && !txn_we) begin
                if (txn_idx == ID_IDX) begin
                    rdata_d = ID_VALUE;
                end else if (txn_idx == CNT_IDX) begin
                    rdata_d = access_cnt_q;
                end else begin
                    rdata_d = mem_q[txn_idx];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            hit_q        <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            access_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            hit_q        <= hit_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            access_cnt_q <= access_cnt_d;
            mem_q        <= mem_d;
        end
    end

    always_comb begin
        wb.wb_ack_o   = (state_q == S_ACK);
        wb.wb_rdata_o = rdata_q;
    end
endmodule

// File: tb/tb_wb_scratch_responder.sv
// Directed bench for wb_scratch_responder: three instances with 0, 1 and 3 wait states.
module tb_wb_scratch_responder;
    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] IDV  = 32'h5742_5253;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    int          sel = 1;
    int          total = 0;
    int          bad = 0;

    logic        cur_ack;
    logic [31:0] cur_rdata;

    always #5 clk = ~clk;

    wb_scratch_responder_if if0 ();
    wb_scratch_responder_if if1 ();
    wb_scratch_responder_if if3 ();

    assign if0.wb_addr_i = addr;  assign if0.wb_wdata_i = wdata;  assign if0.wb_wr_en_i = we;
    assign if0.wb_byte_en_i = be; assign if0.wb_cyc_i = cyc && (sel == 0); assign if0.wb_stb_i = stb && (sel == 0);
    assign if1.wb_addr_i = addr;  assign if1.wb_wdata_i = wdata;  assign if1.wb_wr_en_i = we;
    assign if1.wb_byte_en_i = be; assign if1.wb_cyc_i = cyc && (sel == 1); assign if1.wb_stb_i = stb && (sel == 1);
    assign if3.wb_addr_i = addr;  assign if3.wb_wdata_i = wdata;  assign if3.wb_wr_en_i = we;
    assign if3.wb_byte_en_i = be; assign if3.wb_cyc_i = cyc && (sel == 3); assign if3.wb_stb_i = stb && (sel == 3);

    wb_scratch_responder #(.WAIT_STATES(0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .wb(if0.slave));
    wb_scratch_responder #(.WAIT_STATES(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .wb(if1.slave));
    wb_scratch_responder #(.WAIT_STATES(3)) dut3 (.clk_i(clk), .rst_ni(rst_n), .wb(if3.slave));

    always_comb begin
        cur_ack   = if1.wb_ack_o;
        cur_rdata = if1.wb_rdata_o;
        if (sel == 0) begin
            cur_ack   = if0.wb_ack_o;
            cur_rdata = if0.wb_rdata_o;
        end else if (sel == 3) begin
            cur_ack   = if3.wb_ack_o;
            cur_rdata = if3.wb_rdata_o;
        end
    end

    // Bus transfer on the selected instance; lat counts edges from request to ack.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output int lat,
                        output logic acked);
        @(posedge clk); #1;
        addr = a; we = w; wdata = d; be = b; cyc = 1'b1; stb = 1'b1;
        acked = 1'b0; rd = '0; lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (cur_ack) begin
                acked = 1'b1;
                rd    = cur_rdata;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (if1.wb_ack_o !== 1'b0 || if0.wb_ack_o !== 1'b0 || if3.wb_ack_o !== 1'b0) begin
            bad++; $display("FAIL reset_ack: got %b%b%b want 000", if0.wb_ack_o, if1.wb_ack_o, if3.wb_ack_o); end
        total++; if (if1.wb_rdata_o !== 32'h0) begin
            bad++; $display("FAIL reset_rdata: got %h want 00000000", if1.wb_rdata_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        logic [31:0] rd; int lat; logic ok;
        sel = 1;
        xfer(BASE, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, lat, ok);
        total++; if (ok !== 1'b1 || lat !== 2) begin
            bad++; $display("FAIL wr_latency: got ack=%b lat=%0d want ack=1 lat=2", ok, lat); end
        xfer(BASE, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'hDEAD_BEEF || lat !== 2) begin
            bad++; $display("FAIL rd_word0: got %h lat=%0d want deadbeef lat=2", rd, lat); end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd; int lat; logic ok;
        sel = 1;
        xfer(BASE + 32'h4, 1'b1, 32'hAABB_CCDD, 4'hF, rd, lat, ok);
        xfer(BASE + 32'h4, 1'b1, 32'h1122_3344, 4'b0101, rd, lat, ok);
        xfer(BASE + 32'h4, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'hAA22_CC44) begin
            bad++; $display("FAIL byte_lanes: got %h want aa22cc44", rd); end
        xfer(BASE + 32'h4, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, lat, ok);
        total++; if (ok !== 1'b1) begin
            bad++; $display("FAIL be0_ack: got %b want 1", ok); end
        xfer(BASE + 32'h4, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'hAA22_CC44) begin
            bad++; $display("FAIL be0_nochange: got %h want aa22cc44", rd); end
    endtask

    task automatic test_id;
        logic [31:0] rd; int lat; logic ok;
        sel = 1;
        xfer(BASE + 32'h3C, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== IDV) begin
            bad++; $display("FAIL id_read: got %h want %h", rd, IDV); end
        xfer(BASE + 32'h3C, 1'b1, 32'h0, 4'hF, rd, lat, ok);
        xfer(BASE + 32'h3C, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== IDV) begin
            bad++; $display("FAIL id_readonly: got %h want %h", rd, IDV); end
    endtask

    task automatic test_access_cnt;
        logic [31:0] rd; int lat; logic ok;
        sel = 1;
        xfer(BASE + 32'h38, 1'b1, 32'h1234, 4'hF, rd, lat, ok);
        for (int i = 0; i < 3; i++) xfer(BASE + 32'h8, 1'b1, 32'(i), 4'hF, rd, lat, ok);
        xfer(BASE + 32'h38, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'd3) begin
            bad++; $display("FAIL cnt_three: got %0d want 3", rd); end
        xfer(BASE + 32'h38, 1'b1, 32'hFFFF, 4'hF, rd, lat, ok);
        xfer(BASE + 32'h38, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'd0) begin
            bad++; $display("FAIL cnt_clear: got %0d want 0", rd); end
        @(posedge clk); #1;
        force dut1.access_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut1.access_cnt_q;
        xfer(BASE + 32'h8, 1'b1, 32'h7, 4'hF, rd, lat, ok);
        xfer(BASE + 32'h38, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'd0) begin
            bad++; $display("FAIL cnt_wrap: got %h want 00000000", rd); end
        xfer(BASE + 32'h38, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'd1) begin
            bad++; $display("FAIL cnt_after_wrap: got %0d want 1", rd); end
    endtask

    task automatic test_miss;
        logic [31:0] rd; int lat; logic ok;
        sel = 1;
        xfer(32'h0400_0000, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (ok !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL miss_read: got ack=%b data=%h want ack=1 data=0", ok, rd); end
        xfer(32'h0400_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, lat, ok);
        xfer(BASE, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL miss_write_ignored: got %h want deadbeef", rd); end
        // counter was 2 before the two misses and the word-0 read
        xfer(BASE + 32'h38, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'd5) begin
            bad++; $display("FAIL miss_counted: got %0d want 5", rd); end
    endtask

    task automatic test_zero_wait;
        logic [31:0] rd; int lat; logic ok;
        sel = 0;
        xfer(BASE + 32'h8, 1'b1, 32'h0BAD_F00D, 4'hF, rd, lat, ok);
        total++; if (ok !== 1'b1 || lat !== 1) begin
            bad++; $display("FAIL ws0_latency: got ack=%b lat=%0d want ack=1 lat=1", ok, lat); end
        xfer(BASE + 32'h8, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'h0BAD_F00D || lat !== 1) begin
            bad++; $display("FAIL ws0_read: got %h lat=%0d want 0badf00d lat=1", rd, lat); end
        @(posedge clk); #1;
        total++; if (if0.wb_rdata_o !== 32'h0 || if0.wb_ack_o !== 1'b0) begin
            bad++; $display("FAIL ws0_idle_rdata: got %h ack=%b want 0 ack=0", if0.wb_rdata_o, if0.wb_ack_o); end
    endtask

    task automatic test_abort;
        logic [31:0] rd; int lat; logic ok; logic seen;
        sel = 3;
        xfer(BASE + 32'h14, 1'b1, 32'h5555_AAAA, 4'hF, rd, lat, ok);
        total++; if (ok !== 1'b1 || lat !== 4) begin
            bad++; $display("FAIL ws3_latency: got ack=%b lat=%0d want ack=1 lat=4", ok, lat); end
        @(posedge clk); #1;
        addr = BASE + 32'h14; we = 1'b1; wdata = 32'hFFFF_FFFF; be = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (if3.wb_ack_o) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin
            bad++; $display("FAIL abort_no_ack: got ack seen=%b want 0", seen); end
        xfer(BASE + 32'h14, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'h5555_AAAA) begin
            bad++; $display("FAIL abort_no_write: got %h want 5555aaaa", rd); end
        // addr/wdata changed while waiting must not redirect the write
        @(posedge clk); #1;
        addr = BASE + 32'h18; we = 1'b1; wdata = 32'h0000_0066; be = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        addr = BASE + 32'h1C; wdata = 32'h0000_0077;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (if3.wb_ack_o) begin ok = 1'b1; break; end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        total++; if (ok !== 1'b1) begin
            bad++; $display("FAIL latch_ack: got %b want 1", ok); end
        xfer(BASE + 32'h18, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'h66) begin
            bad++; $display("FAIL latch_word6: got %h want 00000066", rd); end
        xfer(BASE + 32'h1C, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'h0) begin
            bad++; $display("FAIL latch_word7: got %h want 00000000", rd); end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd; int lat; logic ok; logic seen; int nz;
        sel = 3;
        @(posedge clk); #1;
        addr = BASE + 32'h10; we = 1'b1; wdata = 32'hCAFE_CAFE; be = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        seen = 1'b0;
        @(posedge clk); #1;
        if (if3.wb_ack_o) seen = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (if3.wb_ack_o) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin
            bad++; $display("FAIL rst_mid_no_ack: got ack seen=%b want 0", seen); end
        xfer(BASE + 32'h38, 1'b0, '0, 4'h0, rd, lat, ok);
        total++; if (rd !== 32'h0) begin
            bad++; $display("FAIL rst_mid_cnt: got %h want 00000000", rd); end
        nz = 0;
        for (int w = 0; w < 14; w++) begin
            xfer(BASE + 32'(w * 4), 1'b0, '0, 4'h0, rd, lat, ok);
            if (rd !== 32'h0 || ok !== 1'b1) nz++;
        end
        total++; if (nz !== 0) begin
            bad++; $display("FAIL rst_mid_words: got %0d nonzero/unacked words want 0", nz); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_id();
        test_access_cnt();
        test_miss();
        test_zero_wait();
        test_abort();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1, "timeout");
    end
endmodule
